// File: rtl/mmult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmult_pkg
// Brief    : Shared types and constants for the matrix-multiply controller.
// Revision : 1.0
// ============================================================================
package mmult_pkg;

  localparam int MMULT_DIM_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_READ  = 3'd4,
    ST_DONE  = 3'd5
  } mmult_state_t;

  // Cycles needed to drain the skewed wavefront through a DIM x DIM array.
  function automatic int flush_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmult_ctrl_if
// Brief    : Control, A/B feed and result handshake bundle of mmult_ctrl.
// Revision : 1.0
// ============================================================================
interface mmult_ctrl_if #(
  parameter int DIM = mmult_pkg::MMULT_DIM_DEFAULT
);
  import mmult_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   ab_req;
  logic                   ab_vld;
  logic                   ab_load;
  logic                   mem_en;
  logic                   sa_en;
  logic                   sa_clr;
  logic [$clog2(DIM)-1:0] c_sel;
  logic                   c_vld;
  logic                   c_rdy;
  logic [31:0]            perf_cycles;

  modport master (
    input  start, ab_vld, c_rdy,
    output busy, done, ab_req, ab_load, mem_en, sa_en, sa_clr,
           c_sel, c_vld, perf_cycles
  );

  modport slave (
    output start, ab_vld, c_rdy,
    input  busy, done, ab_req, ab_load, mem_en, sa_en, sa_clr,
           c_sel, c_vld, perf_cycles
  );

endinterface
`default_nettype wire

// File: rtl/mmult_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mmult_beat_cnt
// Brief    : Clearable/loadable up-counter with enable and terminal-count flag.
// Revision : 1.0
// ============================================================================
module mmult_beat_cnt #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_clr,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  input  wire logic [WIDTH-1:0] i_tc_val,
  output logic      [WIDTH-1:0] o_cnt,
  output logic                  o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule
`default_nettype wire

// File: rtl/mmult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmult_ctrl
// Brief    : Sequencer for a DIM x DIM systolic matrix multiply: clear, feed,
//            flush, result readout. MMULT_CTRL_PERF_EN adds a cycle counter.
// Revision : 1.0
// ============================================================================
module mmult_ctrl
  import mmult_pkg::*;
#(
  parameter int DIM = MMULT_DIM_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mmult_ctrl_if.master bus
);

  localparam int BW           = $clog2(2 * DIM);
  localparam int RW           = $clog2(DIM);
  localparam int FLUSH_CYCLES = flush_cycles(DIM);

  localparam logic [BW-1:0] c_beat_last  = BW'(DIM - 1);
  localparam logic [BW-1:0] c_flush_last = BW'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0] c_row_last   = RW'(DIM - 1);

  mmult_state_t   r_state;
  mmult_state_t   w_next;
  logic           w_beat_en;
  logic           w_beat_clr;
  logic           w_beat_tc;
  logic [BW-1:0]  w_beat_cnt;
  logic           w_row_en;
  logic           w_row_clr;
  logic           w_row_tc;
  logic [RW-1:0]  w_row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FEED ends on the beat count; FLUSH ends on the counter's terminal flag.
  always_comb begin
    w_next    = r_state;
    w_beat_en = 1'b0;
    w_row_en  = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_FEED;
      ST_FEED: begin
        if (bus.ab_vld) begin
          w_beat_en = 1'b1;
          if (w_beat_cnt == c_beat_last) w_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_beat_en = 1'b1;
        if (w_beat_tc) w_next = ST_READ;
      end
      ST_READ: begin
        if (bus.c_rdy) begin
          if (w_row_tc) w_next = ST_DONE;
          else          w_row_en = 1'b1;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_beat_clr = (w_next != r_state);
  assign w_row_clr  = (r_state == ST_CLEAR) || (r_state == ST_DONE);

  mmult_beat_cnt #(.WIDTH(BW)) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_beat_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_beat_en),
    .i_tc_val   (c_flush_last),
    .o_cnt      (w_beat_cnt),
    .o_tc       (w_beat_tc)
  );

  mmult_beat_cnt #(.WIDTH(RW)) u_row_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_row_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_row_en),
    .i_tc_val   (c_row_last),
    .o_cnt      (w_row_cnt),
    .o_tc       (w_row_tc)
  );

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.sa_clr  = (r_state == ST_CLEAR);
  assign bus.ab_req  = (r_state == ST_FEED);
  assign bus.ab_load = bus.ab_req && bus.ab_vld;
  assign bus.mem_en  = bus.ab_load || (r_state == ST_FLUSH);
  assign bus.sa_en   = bus.ab_load || (r_state == ST_FLUSH);
  assign bus.c_vld   = (r_state == ST_READ);
  assign bus.c_sel   = w_row_cnt;

`ifdef MMULT_CTRL_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_cycles;
  logic [31:0] w_perf_inc;

  assign w_perf_inc = (r_perf_cnt == 32'hFFFF_FFFF) ? r_perf_cnt : r_perf_cnt + 32'd1;

  // The DONE cycle itself is busy, so it is included in the reported total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt    <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (r_state == ST_IDLE) r_perf_cnt <= '0;
      else                    r_perf_cnt <= w_perf_inc;
      if (r_state == ST_DONE) r_perf_cycles <= w_perf_inc;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmult_ctrl
// Brief    : Scoreboard bench for mmult_ctrl with DIM=8 directed scenarios.
// Revision : 1.0
// ============================================================================
module tb_mmult_ctrl;

  localparam int DIM = 8;
  localparam int FL  = 2 * DIM - 1;
`ifdef MMULT_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam int K_CLR   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_FLUSH = 2;
  localparam int K_ROW   = 3;
  localparam int K_DONE  = 4;

  typedef struct {
    int     kind;
    longint val;
    longint val2;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmult_ctrl_if #(.DIM(DIM)) bus ();

  mmult_ctrl #(.DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input longint val, input longint val2);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.val2 = val2;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input longint act, input string name, input longint act2);
    ev_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event value %0d expected no event", name, act);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      if (e.kind == kind) begin
        chk(name, act, e.val);
        if (kind == K_DONE) chk("busy_cycles", act2, e.val2);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events checked against the queue.
  int load_idx  = 0;
  int flush_run = 0;
  int busy_cnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      load_idx  = 0;
      flush_run = 0;
      busy_cnt  = 0;
    end else begin
      busy_cnt = bus.busy ? busy_cnt + 1 : 0;
      if (bus.mem_en || bus.sa_en) chk("sa_en_vs_mem_en", bus.sa_en, bus.mem_en);
      if (bus.sa_clr) begin
        load_idx = 0;
        expect_ev(K_CLR, 0, "sa_clr", 0);
      end
      if (bus.ab_req && !bus.ab_vld)
        chk("feed_freeze", {bus.mem_en, bus.sa_en, bus.ab_load}, 0);
      if (bus.ab_load) begin
        load_idx++;
        expect_ev(K_LOAD, load_idx, "ab_load", 0);
      end
      if (bus.mem_en && !bus.ab_req) flush_run++;
      if (bus.c_vld && flush_run > 0) begin
        expect_ev(K_FLUSH, flush_run, "flush_len", 0);
        flush_run = 0;
      end
      if (bus.c_vld && !bus.c_rdy) begin
        chk("c_sel_hold_ctx", (q.size() > 0) ? q[0].kind : -1, K_ROW);
        if (q.size() > 0 && q[0].kind == K_ROW) chk("c_sel_hold", bus.c_sel, q[0].val);
      end
      if (bus.c_vld && bus.c_rdy) expect_ev(K_ROW, bus.c_sel, "c_sel", 0);
      if (bus.done) expect_ev(K_DONE, bus.perf_cycles, "perf_cycles", busy_cnt);
    end
  end

  // Cycle t=0 is the IDLE cycle presenting start; the schedule below is
  // derived from the state sequence CLEAR, FEED, FLUSH, READ, DONE.
  task automatic run_op(input int stall_at, input int stall_len,
                        input int rdy_row, input int rdy_len, input bit glitch);
    int t_fl, t_rd, t_done;
    t_fl   = 2 + DIM + stall_len;
    t_rd   = t_fl + FL;
    t_done = t_rd + DIM + rdy_len;
    push(K_CLR, 0, 0);
    for (int i = 1; i <= DIM; i++) push(K_LOAD, i, 0);
    push(K_FLUSH, FL, 0);
    for (int r = 0; r < DIM; r++) push(K_ROW, r, 0);
    push(K_DONE, PERF_ON ? t_done : 0, t_done);
    for (int t = 0; t <= t_done; t++) begin
      int f;
      f = t - 2;
      bus.start  = (t == 0) || (glitch && (t == t_fl + 3 || t == t_done));
      bus.ab_vld = !(f >= stall_at && f < stall_at + stall_len);
      bus.c_rdy  = !(t >= t_rd + rdy_row && t < t_rd + rdy_row + rdy_len);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("queue_drained", q.size(), 0);
    chk("perf_held", bus.perf_cycles, PERF_ON ? t_done : 0);
    q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.busy, bus.done, bus.ab_req, bus.ab_load, bus.mem_en,
               bus.sa_en, bus.sa_clr, bus.c_vld}, 0);
    chk({name, "_c_sel"}, bus.c_sel, 0);
    chk({name, "_perf"}, bus.perf_cycles, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.ab_vld = 1'b0;
    bus.c_rdy  = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(DIM + 1, 0, DIM + 1, 0, 1'b0);   // nominal back-to-back stream
    @(posedge clk); #1;
    run_op(4, 3, DIM + 1, 0, 1'b0);         // source stalls after 4th row
    @(posedge clk); #1;
    run_op(DIM + 1, 0, 5, 2, 1'b0);         // sink stalls at row 5
    @(posedge clk); #1;
    run_op(DIM + 1, 0, DIM + 1, 0, 1'b1);   // stray start in FLUSH and DONE
    @(posedge clk); #1;

    // Abandon an operation in FEED after three transfers.
    push(K_CLR, 0, 0);
    for (int i = 1; i <= 3; i++) push(K_LOAD, i, 0);
    for (int t = 0; t < 5; t++) begin
      bus.start  = (t == 0);
      bus.ab_vld = 1'b1;
      bus.c_rdy  = 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    chk("mid_reset_queue", q.size(), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
    @(posedge clk); #1;
    run_op(DIM + 1, 0, DIM + 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mmult_ctrl.md
MMULT_CTRL -- requirements
Module: mmult_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning systolic array dimension (rows = columns = skew FIFO count).
REQ-002 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: start  in  1  request one matrix multiply; busy  out  1  operation in progress; done  out  1  one-cycle completion pulse.
REQ-004 SHALL have ports: ab_req  out  1  ready for next A/B row; ab_vld  in  1  source presents A/B row; ab_load  out  1  row transferred this cycle (ab_req & ab_vld).
REQ-005 SHALL have ports: mem_en  out  1  enable to A and B skew FIFOs; sa_en  out  1  systolic array enable; sa_clr  out  1  accumulator clear pulse.
REQ-006 SHALL have ports: c_sel  out  $clog2(DIM)  result row index; c_vld  out  1  result row valid; c_rdy  in  1  sink accepts result row.
REQ-007 SHALL have port perf_cycles  out  32  cycle count of last operation (see Configuration).

Function
REQ-008 SHALL implement states IDLE, CLEAR, FEED, FLUSH, READ, DONE.
REQ-009 IDLE: start=1 -> CLEAR next cycle; start ignored in every other state.
REQ-010 CLEAR: sa_clr=1 for exactly one cycle; beat counter zeroed; -> FEED.
REQ-011 FEED: ab_req=1; each cycle with ab_vld=1 asserts ab_load, mem_en, sa_en and increments beat counter.
REQ-012 FEED with ab_vld=0: mem_en=sa_en=0 (whole pipeline frozen); counter holds; no timeout.
REQ-013 FEED: on the DIM-th transfer -> FLUSH next cycle; ab_req=0 outside FEED.
REQ-014 FLUSH: mem_en=sa_en=1 every cycle for exactly FLUSH_CYCLES = 2*DIM-1 cycles (skew FIFOs self-feed zeros); -> READ.
REQ-015 READ: c_vld=1, c_sel starts at 0; each cycle with c_vld & c_rdy increments c_sel; c_rdy=0 holds c_sel; mem_en=sa_en=0.
REQ-016 READ: transfer at c_sel=DIM-1 -> DONE; c_sel does not wrap to 0 before leaving READ.
REQ-017 DONE: done=1 one cycle, -> IDLE; start in the DONE cycle is ignored.
REQ-018 busy=1 in all states except IDLE.
REQ-019 All outputs SHALL be registered or decoded solely from state/counters; no combinational path from ab_vld to mem_en other than the REQ-011 qualification.
REQ-020 Beat counter width $clog2(2*DIM) bits; no overflow for any DIM>=2.

Reset
REQ-021 rst_n=0 SHALL force state IDLE and every output to 0 (c_sel=0, perf_cycles=0) asynchronously.
REQ-022 Reset mid-operation SHALL abandon the operation with no done pulse; next start begins from CLEAR.

Configuration
REQ-023 Macro MMULT_CTRL_PERF_EN defined: 32-bit counter cleared on leaving IDLE, incremented each cycle while busy, saturating at 2^32-1, copied to perf_cycles in the DONE cycle and held until the next DONE.
REQ-024 Macro MMULT_CTRL_PERF_EN undefined: no counter logic; perf_cycles tied to 0; all other behaviour identical.

Structure
REQ-025 Package mmult_pkg SHALL hold the state enum type mmult_state_t, default DIM, and FLUSH_CYCLES function of DIM.
REQ-026 A sub-module mmult_beat_cnt (loadable/clearable up-counter with enable and terminal-count compare) SHALL be used for beat, flush and row counting.

Verification (DIM=8)
REQ-027 start, ab_vld held 1, c_rdy held 1 -> sa_clr at cycle 1, 8 ab_load pulses, 15 FLUSH cycles, c_sel 0..7, done once; total busy 33 cycles; perf_cycles=33 with macro.
REQ-028 ab_vld low 3 cycles after 4th transfer -> mem_en=sa_en=0 those 3 cycles, counter holds at 4, exactly 8 ab_load pulses total.
REQ-029 c_rdy low 2 cycles at c_sel=5 -> c_sel holds 5, c_vld stays 1, done one cycle after c_sel=7 accepted.
REQ-030 start pulsed during FLUSH and during DONE -> ignored; exactly one done; returns to IDLE with busy=0.
REQ-031 rst_n asserted during FEED after 3 transfers -> all outputs 0 immediately, no done; new start yields full 8-row sequence.
REQ-032 Macro undefined build, scenario REQ-027 -> perf_cycles=0, all other outputs identical cycle-for-cycle.
